// File: rtl/arm_pkg.sv
// arm_pkg: shared fetch-path widths, constants and the queued entry type
package arm_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer of fetch entries; flush beats push and pop
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  fetch_entry_t            din,
  output fetch_entry_t            dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push & ~flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: PC owner, single-outstanding imem fetcher and prefetch FIFO feeding IF_stage_reg
// Optional PREFETCH_STATS_EN adds saturating drop / empty-cycle counters.
module if_prefetch_queue
  import arm_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_address,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [WORD_W-1:0] pc_out,
`ifdef PREFETCH_STATS_EN
  output logic [WORD_W-1:0] instruction_out,
  output logic [15:0]       stat_drop_count,
  output logic [15:0]       stat_empty_cycles
`else
  output logic [WORD_W-1:0] instruction_out
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_nx, addr_nx;
  logic ack, push, pop, issue, full, empty, drop, drop_nx, req_nx;
  logic [CW-1:0] count, count_nx;
  fetch_entry_t head;
  assign ack = imem_req & imem_ack;
  assign push = ack & ~drop & ~branch_taken;
  assign pop = ~empty & ~freeze & ~branch_taken;
  assign count_nx = count + CW'(push) - CW'(pop);
  // a completing fetch may hand straight over to the next one if its slot is free
  assign issue = ~branch_taken & (imem_req ? ack & (count_nx < CW'(DEPTH)) : ~full);
  always_comb begin
    fetch_pc_nx = branch_taken ? branch_address : push ? imem_addr + PC_INC : fetch_pc;
    req_nx = (imem_req & ~imem_ack) | issue;
    drop_nx = branch_taken ? imem_req & ~imem_ack : drop & ~ack;
    addr_nx = issue ? fetch_pc_nx : imem_addr;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      drop <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nx;
      imem_req <= req_nx;
      imem_addr <= addr_nx;
      drop <= drop_nx;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(branch_taken),
    .din(fetch_entry_t'({imem_addr + PC_INC, imem_rdata})),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign out_valid = ~empty;
  assign pc_out = empty ? '0 : head.pc;
  assign instruction_out = empty ? '0 : head.instr;
`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_drop_count <= '0;
      stat_empty_cycles <= '0;
    end else begin
      if (ack & (drop | branch_taken) & ~&stat_drop_count) stat_drop_count <= stat_drop_count + 16'd1;
      if (empty & ~&stat_empty_cycles) stat_empty_cycles <= stat_empty_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: queue-level reference model plus directed fetch/branch/freeze/reset scenarios
module tb_if_prefetch_queue;
  import arm_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, freeze = 0, branch_taken = 0, imem_ack = 0;
  logic [31:0] branch_address = 0, imem_rdata = 0;
  logic imem_req, out_valid, req2, ov2;
  logic [31:0] imem_addr, pc_out, instruction_out, addr2, pc2, in2;
  int total = 0, bad = 0, lat = 0, w = 0;
  fetch_entry_t q[$];
  logic [31:0] mpc, exp_addr;
  logic exp_req, stale, hs, dp;
  int n0, m_drops, m_empty;
  logic [31:0] w_pc[3], w_in[3], w_ad[3];
  int n_out = 0, n_ad = 0;
`ifdef PREFETCH_STATS_EN
  logic [15:0] sd, se, sd2, se2;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
`ifdef PREFETCH_STATS_EN
    .pc_out(pc_out), .instruction_out(instruction_out),
    .stat_drop_count(sd), .stat_empty_cycles(se)
`else
    .pc_out(pc_out), .instruction_out(instruction_out)
`endif
  );

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
    .branch_address(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(addr2 >> 2), .out_valid(ov2),
`ifdef PREFETCH_STATS_EN
    .pc_out(pc2), .instruction_out(in2),
    .stat_drop_count(sd2), .stat_empty_cycles(se2)
`else
    .pc_out(pc2), .instruction_out(in2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // memory: acks a request after it has been visible for lat cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (!imem_req) begin
      imem_ack = 0;
      w = 0;
    end else begin
      imem_ack = (w >= lat);
      imem_rdata = imem_addr >> 2;
      w = imem_ack ? 0 : w + 1;
    end
  end

  // reference model: compare what the last edge produced, then advance to the next edge
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      mpc = 32'h0; exp_req = 0; exp_addr = 32'h0; stale = 0; m_drops = 0; m_empty = 0;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("pc_out", pc_out, q.size() != 0 ? q[0].pc : 32'h0);
    chk("instruction_out", instruction_out, q.size() != 0 ? q[0].instr : 32'h0);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
`ifdef PREFETCH_STATS_EN
    chk("stat_drop_count", {16'b0, sd}, 32'(m_drops));
    chk("stat_empty_cycles", {16'b0, se}, 32'(m_empty));
`endif
    if (rst) begin
      n0 = q.size();
      hs = exp_req && imem_ack;
      dp = n0 > 0 && !freeze && !branch_taken;
      if (n0 == 0) m_empty++;
      if (branch_taken) begin
        if (hs) m_drops++;
        q.delete();
        mpc = branch_address;
        stale = exp_req && !imem_ack;
        exp_req = exp_req && !imem_ack;
      end else begin
        if (dp) void'(q.pop_front());
        if (hs) begin
          if (stale) begin
            stale = 0;
            m_drops++;
          end else begin
            q.push_back(fetch_entry_t'({exp_addr + 32'd4, imem_rdata}));
            mpc = exp_addr + 32'd4;
          end
        end
        if (!(exp_req && !imem_ack)) begin
          if ((exp_req ? q.size() : n0) < DEPTH) begin
            exp_req = 1;
            exp_addr = mpc;
          end else exp_req = 0;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst) begin
      if (ov2 && n_out < 3) begin
        w_pc[n_out] = pc2;
        w_in[n_out] = in2;
        n_out++;
      end
      if (req2 && n_ad < 3) begin
        w_ad[n_ad] = addr2;
        n_ad++;
      end
    end

  initial begin
    cyc(2);
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst instr", instruction_out, 32'h0);
    rst = 1;
    cyc(1);
    chk("first req", {31'b0, imem_req}, 32'h1);
    chk("first addr", imem_addr, 32'h0);
    chk("first valid low", {31'b0, out_valid}, 32'h0);
    cyc(1);
    chk("seq valid", {31'b0, out_valid}, 32'h1);
    chk("seq pc 4", pc_out, 32'd4);
    chk("seq instr 0", instruction_out, 32'd0);
    chk("seq addr 4", imem_addr, 32'd4);
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      chk("seq pc", pc_out, 32'(4 * (i + 1)));
      chk("seq instr", instruction_out, 32'(i));
    end
    chk("seq addr 16", imem_addr, 32'd16);
    freeze = 1;
    cyc(6);
    chk("full req low", {31'b0, imem_req}, 32'h0);
    chk("full valid", {31'b0, out_valid}, 32'h1);
    chk("freeze head", pc_out, 32'd16);
    freeze = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("drain pc", pc_out, 32'(20 + 4 * i));
    end
    lat = 3;
    for (int i = 0; i < 50 && !(imem_req && w == 2); i++) cyc(1);
    chk("wait cycle 1 seen", {31'b0, imem_req && w == 2}, 32'h1);
    branch_taken = 1;
    branch_address = 32'h100;
    cyc(1);
    branch_taken = 0;
    chk("br1 flushed", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 20 && !(imem_req && imem_ack); i++) cyc(1);
    cyc(1);
    chk("br1 req", {31'b0, imem_req}, 32'h1);
    chk("br1 addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !out_valid; i++) cyc(1);
    chk("br1 pc", pc_out, 32'h104);
    chk("br1 instr", instruction_out, 32'h40);
    lat = 0;
    for (int i = 0; i < 50 && !(imem_req && imem_ack && out_valid); i++) cyc(1);
    chk("br2 setup", {31'b0, imem_req && imem_ack && out_valid}, 32'h1);
    branch_taken = 1;
    branch_address = 32'h200;
    cyc(1);
    branch_taken = 0;
    chk("br2 flushed", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 20 && !imem_req; i++) cyc(1);
    chk("br2 addr", imem_addr, 32'h200);
    for (int i = 0; i < 20 && !out_valid; i++) cyc(1);
    chk("br2 pc", pc_out, 32'h204);
    chk("br2 instr", instruction_out, 32'h80);
    freeze = 1;
    lat = 3;
    for (int i = 0; i < 100 && !(q.size() == 2 && imem_req && !imem_ack); i++) cyc(1);
    chk("mid rst setup", {31'b0, q.size() == 2 && imem_req}, 32'h1);
    rst = 0;
    #1;
    chk("mid rst req", {31'b0, imem_req}, 32'h0);
    chk("mid rst valid", {31'b0, out_valid}, 32'h0);
    chk("mid rst pc", pc_out, 32'h0);
    chk("mid rst addr", imem_addr, 32'h0);
`ifdef PREFETCH_STATS_EN
    chk("mid rst drops", {16'b0, sd}, 32'h0);
    chk("mid rst empties", {16'b0, se}, 32'h0);
`endif
    cyc(2);
    rst = 1;
    freeze = 0;
    lat = 0;
    for (int i = 0; i < 20 && !imem_req; i++) cyc(1);
    chk("restart addr", imem_addr, 32'h0);
    cyc(10);
    chk("wrap outs", 32'(n_out), 32'd3);
    chk("wrap addr0", w_ad[0], 32'hFFFF_FFF8);
    chk("wrap addr1", w_ad[1], 32'hFFFF_FFFC);
    chk("wrap addr2", w_ad[2], 32'h0);
    chk("wrap pc0", w_pc[0], 32'hFFFF_FFFC);
    chk("wrap pc1", w_pc[1], 32'h0);
    chk("wrap pc2", w_pc[2], 32'h4);
    chk("wrap in0", w_in[0], 32'h3FFF_FFFE);
    chk("wrap in1", w_in[1], 32'h3FFF_FFFF);
    chk("wrap in2", w_in[2], 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
